// File: rtl/plm_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plm_sched_pkg
// Description : Shared types and width helpers for the PLM scheduling kernels
//               and the PLM response router.
//               - plm_tag_t   : grant tag {valid, consumer, wr} carried down the
//                               read-latency pipe
//               - plm_*()     : derived widths (kernel count, consumer-index
//                               width, counter width, request/PLM bus widths)
// Revision    : 1.0 - initial release
// ============================================================================
package plm_sched_pkg;

   // Widest consumer index a tag can carry. The tag is a fixed-layout struct
   // so it can live in a package; narrower indices are zero-extended into it.
   localparam int CID_MAX_W = 8;

   typedef struct packed {
      logic                 valid;
      logic [CID_MAX_W-1:0] consumer;
      logic                 wr;
   } plm_tag_t;

   function automatic int plm_nkernels(input int nbanks, input int nports);
      return nbanks * nports;
   endfunction

   function automatic int plm_cid_w(input int nconsumers);
      return (nconsumers > 1) ? $clog2(nconsumers) : 1;
   endfunction

   // Outstanding counter must hold every grant that can be in flight.
   function automatic int plm_out_w(input int nkernels, input int read_latency);
      return $clog2(nkernels * (read_latency + 1) + 1);
   endfunction

   // One consumer request: write flag, address, write data.
   function automatic int plm_req_width(input int addr_w, input int value_w);
      return 1 + addr_w + value_w;
   endfunction

   // Flattened PLM input bus: one {we, addr, wdata} per kernel.
   function automatic int plm_input_width(input int nkernels, input int addr_w,
                                          input int value_w);
      return nkernels * (1 + addr_w + value_w);
   endfunction

   // Flattened PLM output bus: one read word per kernel.
   function automatic int plm_output_width(input int nkernels, input int value_w);
      return nkernels * value_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/plm_tag_delay.sv
`default_nettype none
// ============================================================================
// Module      : plm_tag_delay
// Description : Fixed-depth shift register of grant tags, aligning a kernel's
//               grant with the PLM read data it produces DEPTH cycles later.
// Ports       : clk     - rising-edge clock
//               reset_n - asynchronous active-low clear of all stages
//               tag_i   - tag captured into stage 0 every cycle
//               tag_o   - final-stage tag
//               busy_o  - any stage holds a valid tag
// Revision    : 1.0 - initial release
// ============================================================================
module plm_tag_delay
   import plm_sched_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic     clk,
   input  logic     reset_n,
   input  plm_tag_t tag_i,
   output plm_tag_t tag_o,
   output logic     busy_o
);

   plm_tag_t stage_q [DEPTH];
   plm_tag_t stage_d [DEPTH];

   always_comb begin
      stage_d[0] = tag_i;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_o = busy_o | stage_q[i].valid;
      end
   end

   assign tag_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/plm_response_router.sv
`default_nettype none
// ============================================================================
// Module      : plm_response_router
// Description : Routes PLM read data / write completions back to the consumer
//               that each kernel granted, PLM_READ_LATENCY+1 cycles after the
//               grant, and tracks per-consumer outstanding requests.
// Ports       : clk, reset_n          - clock, async active-low reset
//               grant_valid/consumer/wr - per-kernel grant this cycle
//               plm_outputs           - per-kernel PLM read word
//               resp_valid/resp_data  - per-consumer read response pulse/data
//               resp_wr_ack           - per-consumer write completion pulse
//               outstanding           - per-consumer in-flight request count
//               idle                  - nothing outstanding, all pipes empty
//               route_err             - sticky collision/bad-index/saturation
// Revision    : 1.0 - initial release
// ============================================================================
module plm_response_router
   import plm_sched_pkg::*;
#(
   parameter int ADDR_WIDTH       = 4,
   parameter int VALUE_WIDTH      = 8,
   parameter int NCONSUMERS       = 2,
   parameter int NBANKS           = 1,
   parameter int NPORTS           = 1,
   parameter int PLM_READ_LATENCY = 1,
   localparam int NKERNELS        = plm_nkernels(NBANKS, NPORTS),
   localparam int CID_W           = plm_cid_w(NCONSUMERS),
   localparam int OUT_W           = plm_out_w(NKERNELS, PLM_READ_LATENCY)
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NKERNELS-1:0]                  grant_valid,
   input  logic [NKERNELS-1:0][CID_W-1:0]       grant_consumer,
   input  logic [NKERNELS-1:0]                  grant_wr,
   input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0] plm_outputs,
   output logic [NCONSUMERS-1:0]                resp_valid,
   output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data,
   output logic [NCONSUMERS-1:0]                resp_wr_ack,
   output logic [NCONSUMERS-1:0][OUT_W-1:0]     outstanding,
   output logic                                 idle,
   output logic                                 route_err
);

   localparam int OUT_MAX = (2 ** OUT_W) - 1;

   if (ADDR_WIDTH < 1 || PLM_READ_LATENCY < 1 || NPORTS < 1 || NPORTS > 2 ||
       CID_W > CID_MAX_W) begin : g_param_check
      $error("plm_response_router: unsupported parameter combination");
   end

   // -------------------------------------------------------------------------
   // Tag capture and latency alignment
   // -------------------------------------------------------------------------
   plm_tag_t              cap_tag  [NKERNELS];
   plm_tag_t              fin_tag  [NKERNELS];
   logic [NKERNELS-1:0]   pipe_busy;
   logic [NKERNELS-1:0]   bad_idx;

   // Out-of-range consumer indices never enter the pipe as valid tags, so
   // they cannot produce a response or touch any counter.
   always_comb begin
      for (int k = 0; k < NKERNELS; k++) begin
         cap_tag[k].valid    = grant_valid[k] && (int'(grant_consumer[k]) < NCONSUMERS);
         cap_tag[k].consumer = CID_MAX_W'(grant_consumer[k]);
         cap_tag[k].wr       = grant_wr[k];
         bad_idx[k]          = grant_valid[k] && (int'(grant_consumer[k]) >= NCONSUMERS);
      end
   end

   for (genvar k = 0; k < NKERNELS; k++) begin : g_tag_delay
      plm_tag_delay #(
         .DEPTH (PLM_READ_LATENCY)
      ) u_tag_delay (
         .clk     (clk),
         .reset_n (reset_n),
         .tag_i   (cap_tag[k]),
         .tag_o   (fin_tag[k]),
         .busy_o  (pipe_busy[k])
      );
   end

   // -------------------------------------------------------------------------
   // Response routing, outstanding counters, error flag
   // -------------------------------------------------------------------------
   logic [NCONSUMERS-1:0]                  resp_valid_q,  resp_valid_d;
   logic [NCONSUMERS-1:0]                  resp_wr_ack_q, resp_wr_ack_d;
   logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data_q,   resp_data_d;
   logic [NCONSUMERS-1:0][OUT_W-1:0]       out_q,         out_d;
   logic                                   err_q,         err_d;

   always_comb begin
      logic hit;
      logic collide;
      logic sat_err;
      int   inc;
      int   dec;
      int   nxt;

      resp_valid_d  = '0;
      resp_wr_ack_d = '0;
      resp_data_d   = resp_data_q;
      out_d         = out_q;
      hit           = 1'b0;
      collide       = 1'b0;
      sat_err       = 1'b0;
      inc           = 0;
      dec           = 0;
      nxt           = 0;

      for (int c = 0; c < NCONSUMERS; c++) begin
         hit = 1'b0;
         inc = 0;
         dec = 0;
         // Ascending kernel scan: the first hit is the lowest index and wins;
         // any later hit for the same consumer is a dropped collision.
         for (int k = 0; k < NKERNELS; k++) begin
            if (fin_tag[k].valid && fin_tag[k].consumer == CID_MAX_W'(c)) begin
               dec = dec + 1;
               if (!hit) begin
                  hit = 1'b1;
                  if (fin_tag[k].wr) begin
                     resp_wr_ack_d[c] = 1'b1;
                  end else begin
                     resp_valid_d[c] = 1'b1;
                     resp_data_d[c]  = plm_outputs[k];
                  end
               end else begin
                  collide = 1'b1;
               end
            end
            if (cap_tag[k].valid && cap_tag[k].consumer == CID_MAX_W'(c)) begin
               inc = inc + 1;
            end
         end

         nxt = int'(out_q[c]) + inc - dec;
         if (nxt < 0) begin
            out_d[c] = '0;
            sat_err  = 1'b1;
         end else if (nxt > OUT_MAX) begin
            out_d[c] = OUT_W'(OUT_MAX);
            sat_err  = 1'b1;
         end else begin
            out_d[c] = OUT_W'(nxt);
         end
      end

      err_d = err_q | (|bad_idx) | collide | sat_err;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid_q  <= '0;
         resp_wr_ack_q <= '0;
         resp_data_q   <= '0;
         out_q         <= '0;
         err_q         <= 1'b0;
      end else begin
         resp_valid_q  <= resp_valid_d;
         resp_wr_ack_q <= resp_wr_ack_d;
         resp_data_q   <= resp_data_d;
         out_q         <= out_d;
         err_q         <= err_d;
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_wr_ack = resp_wr_ack_q;
   assign resp_data   = resp_data_q;
   assign outstanding = out_q;
   assign route_err   = err_q;
   assign idle        = (out_q == '0) && !(|pipe_busy);

endmodule
`default_nettype wire

// File: tb/tb_plm_response_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_plm_response_router
// Description : Randomised scoreboard bench for plm_response_router
//               (L=3, 3 consumers, 2 kernels). The driver computes expected
//               responses from the grant rules and queues them; an independent
//               monitor compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plm_response_router;

   localparam int L    = 3;
   localparam int NC   = 3;
   localparam int NK   = 2;
   localparam int VW   = 8;
   localparam int CW   = 2;
   localparam int OW   = 4;
   localparam int NCYC = 1024;
   localparam int BIG  = 1 << 30;

   logic                    clk = 1'b0;
   logic                    reset_n;
   logic [NK-1:0]           grant_valid;
   logic [NK-1:0][CW-1:0]   grant_consumer;
   logic [NK-1:0]           grant_wr;
   logic [NK-1:0][VW-1:0]   plm_outputs;
   logic [NC-1:0]           resp_valid;
   logic [NC-1:0][VW-1:0]   resp_data;
   logic [NC-1:0]           resp_wr_ack;
   logic [NC-1:0][OW-1:0]   outstanding;
   logic                    idle;
   logic                    route_err;

   always #5 clk = ~clk;

   plm_response_router #(
      .ADDR_WIDTH       (4),
      .VALUE_WIDTH      (VW),
      .NCONSUMERS       (NC),
      .NBANKS           (1),
      .NPORTS           (2),
      .PLM_READ_LATENCY (L)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .grant_valid    (grant_valid),
      .grant_consumer (grant_consumer),
      .grant_wr       (grant_wr),
      .plm_outputs    (plm_outputs),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .resp_wr_ack    (resp_wr_ack),
      .outstanding    (outstanding),
      .idle           (idle),
      .route_err      (route_err)
   );

   typedef struct {
      int          due;
      int          c;
      bit          wr;
      logic [VW-1:0] data;
   } exp_t;

   exp_t          q[$];
   logic [VW-1:0] data_arr [NCYC][NK];
   int            hist     [NCYC][NC];   // accepted grants per cycle per consumer
   logic [VW-1:0] last_data  [NC];       // driver view: last read data queued
   logic [VW-1:0] model_last [NC];       // monitor view: last read data delivered
   int            n;
   int            rst_last;
   int            err_at;
   int            checks;
   int            errors;
   bit            started;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      n = n + 1;
   endtask

   // One cycle of stimulus plus the reference model's consequences.
   task automatic drive_cycle(input int pvalid, input bit allow_col, input bit allow_bad);
      bit gvs  [NK];
      int gcs  [NK];
      bit gws  [NK];
      bit used [NC];
      int cnt;
      exp_t e;
      for (int c = 0; c < NC; c++) used[c] = 1'b0;
      for (int k = 0; k < NK; k++) begin
         gvs[k] = ($urandom_range(0, 99) < pvalid);
         gcs[k] = $urandom_range(0, NC - 1);
         gws[k] = ($urandom_range(0, 2) == 0);
         if (allow_bad && $urandom_range(0, 4) == 0) begin
            gcs[k] = 3;
         end else if (!allow_col && gvs[k]) begin
            for (int j = 0; j < NC && used[gcs[k]]; j++) gcs[k] = (gcs[k] + 1) % NC;
         end
         if (gvs[k] && gcs[k] < NC) used[gcs[k]] = 1'b1;
         if (gvs[k] && gcs[k] >= NC && (n + 1) < err_at) err_at = n + 1;
         grant_valid[k]    = gvs[k];
         grant_consumer[k] = CW'(gcs[k]);
         grant_wr[k]       = gws[k];
         plm_outputs[k]    = data_arr[n][k];
      end
      for (int c = 0; c < NC; c++) begin
         cnt = 0;
         for (int k = 0; k < NK; k++) begin
            if (gvs[k] && gcs[k] == c) begin
               cnt = cnt + 1;
               if (cnt == 1) begin
                  e.due  = n + L + 1;
                  e.c    = c;
                  e.wr   = gws[k];
                  e.data = gws[k] ? last_data[c] : data_arr[n + L][k];
                  if (!gws[k]) last_data[c] = e.data;
                  q.push_back(e);
               end
            end
         end
         hist[n][c] = cnt;
         if (cnt > 1 && (n + L + 1) < err_at) err_at = n + L + 1;
      end
      next_cycle();
   endtask

   task automatic do_reset(input int cycles);
      reset_n        = 1'b0;
      grant_valid    = '0;
      grant_consumer = '0;
      grant_wr       = '0;
      q.delete();
      err_at = BIG;
      for (int c = 0; c < NC; c++) begin
         last_data[c]  = '0;
         model_last[c] = '0;
      end
      for (int i = 0; i < cycles; i++) begin
         rst_last = n;
         for (int c = 0; c < NC; c++) hist[n][c] = 0;
         next_cycle();
      end
      reset_n = 1'b1;
   endtask

   // Monitor: outstanding = accepted grants of the last L cycles since reset.
   always @(negedge clk) begin
      int   s;
      int   total;
      int   t0;
      exp_t e;
      if (started) begin
         total = 0;
         t0 = (n - L > rst_last + 1) ? n - L : rst_last + 1;
         for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int t = t0; t < n; t++) s = s + hist[t][c];
            chk("outstanding", 32'(outstanding[c]), s);
            total = total + s;
         end
         chk("idle", 32'(idle), 32'(total == 0));
         chk("route_err", 32'(route_err), 32'(n >= err_at));
         for (int c = 0; c < NC; c++) begin
            if (resp_valid[c] || resp_wr_ack[c]) begin
               if (q.size() > 0 && q[0].due == n && q[0].c == c) begin
                  e = q.pop_front();
                  chk("resp_valid", 32'(resp_valid[c]), 32'(!e.wr));
                  chk("resp_wr_ack", 32'(resp_wr_ack[c]), 32'(e.wr));
                  if (!e.wr) model_last[c] = e.data;
               end else begin
                  checks = checks + 1;
                  errors = errors + 1;
                  $display("FAIL unexpected_resp cycle %0d consumer %0d: got valid=%0b ack=%0b expected none",
                           n, c, resp_valid[c], resp_wr_ack[c]);
               end
            end
         end
         while (q.size() > 0 && q[0].due <= n) begin
            e = q.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL missing_resp cycle %0d consumer %0d: got no pulse expected wr=%0b due %0d",
                     n, e.c, e.wr, e.due);
            if (!e.wr) model_last[e.c] = e.data;
         end
         for (int c = 0; c < NC; c++) chk("resp_data", 32'(resp_data[c]), 32'(model_last[c]));
      end
   end

   initial begin
      reset_n        = 1'b0;
      grant_valid    = '0;
      grant_consumer = '0;
      grant_wr       = '0;
      plm_outputs    = '0;
      n        = 0;
      rst_last = 0;
      err_at   = BIG;
      checks   = 0;
      errors   = 0;
      started  = 1'b0;
      for (int t = 0; t < NCYC; t++) begin
         for (int k = 0; k < NK; k++) data_arr[t][k] = VW'($urandom);
         for (int c = 0; c < NC; c++) hist[t][c] = 0;
      end
      #1;
      started = 1'b1;
      do_reset(3);
      // clean traffic: route_err must stay low
      for (int i = 0; i < 60; i++) drive_cycle(60, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)  drive_cycle(0, 1'b0, 1'b0);
      // collisions allowed
      for (int i = 0; i < 60; i++) drive_cycle(70, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++)  drive_cycle(100, 1'b1, 1'b0);
      // reset with tags in flight
      do_reset(2);
      // bad consumer indices, no collisions
      for (int i = 0; i < 40; i++) drive_cycle(60, 1'b0, 1'b1);
      do_reset(2);
      // full rate on every kernel, then drain to idle
      for (int i = 0; i < 100; i++) drive_cycle(100, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++)  drive_cycle(0, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/plm_response_router.md
Name: plm_response_router

Overview:
- Sits directly downstream of the round-robin scheduling kernels and the PLM banks.
- Captures each kernel's per-cycle grant (which consumer, read or write) as a tag, and delays that tag to match the PLM read latency.
- Routes each bank/port's plm_outputs word back to the granted consumer as a one-cycle response pulse.
- Keeps per-consumer outstanding-request counters so consumers can tell when all their issued requests have completed.

Parameters:
- ADDR_WIDTH, 4: consumer request address width; carried only for package consistency.
- VALUE_WIDTH, 8: PLM data word width.
- NCONSUMERS, 2: number of consumers (at least 2).
- NBANKS, 1: number of PLM banks.
- NPORTS, 1: ports per bank, 1 or 2. NKERNELS = NBANKS*NPORTS, at least 2.
- PLM_READ_LATENCY, 1: cycles from a PLM input presented to its output valid, at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- grant_valid  in  [NKERNELS] x 1  kernel k issued an eligible request to its PLM this cycle.
- grant_consumer  in  [NKERNELS] x CID_W  consumer index granted by kernel k; CID_W = $clog2(NCONSUMERS).
- grant_wr  in  [NKERNELS] x 1  granted request is a write.
- plm_outputs  in  [NKERNELS] x VALUE_WIDTH  PLM read data for kernel k.
- resp_valid  out  [NCONSUMERS] x 1  one-cycle pulse: read data delivered.
- resp_data  out  [NCONSUMERS] x VALUE_WIDTH  read data for consumer c.
- resp_wr_ack  out  [NCONSUMERS] x 1  one-cycle pulse: write completed.
- outstanding  out  [NCONSUMERS] x OUT_W  issued-but-unanswered requests; OUT_W = $clog2(NKERNELS*(PLM_READ_LATENCY+1)+1).
- idle  out  1  all outstanding counters are zero and all tag pipes are empty.
- route_err  out  1  sticky error flag.

Behaviour:
- Async reset (reset_n low):
  - All tag-pipe stages invalid; outstanding = 0.
  - resp_valid, resp_wr_ack, resp_data = 0; route_err = 0; idle = 1.
  - Reset asserted mid-operation flushes all in-flight tags. No response is ever emitted for a flushed tag.
- Tag capture:
  - At each posedge, per kernel k, stage 0 of a PLM_READ_LATENCY-deep shift register loads {grant_valid[k], grant_consumer[k], grant_wr[k]}.
  - Stages shift every cycle; there is no stall.
- Delivery timing:
  - A grant sampled at edge T has its tag at the final stage during cycle T+L, where L = PLM_READ_LATENCY.
  - plm_outputs[k] is sampled in that same cycle.
  - Outputs are registered, so resp_valid, resp_data and resp_wr_ack become visible after edge T+L+1.
  - Total grant-to-response latency = L+1 cycles.
- Response type:
  - Read tag (wr = 0): resp_valid[c] = 1 and resp_data[c] = plm_outputs[k].
  - Write tag (wr = 1): resp_wr_ack[c] = 1; resp_data[c] is unchanged.
  - resp_data holds its last delivered value while resp_valid is low.
- Collision:
  - If more than one final-stage tag targets the same consumer c in the same cycle, the lowest kernel index wins.
  - The losers are dropped and route_err is set.
  - The outstanding counter is still decremented once per completed tag, losers included.
- Bad index: a grant with grant_consumer >= NCONSUMERS is captured as invalid and sets route_err. No counter changes.
- Outstanding counters:
  - Per consumer: +1 per valid grant and -1 per final-stage valid tag, in the same cycle; the net delta is applied.
  - Counters saturate at max and at 0. Underflow or overflow sets route_err.
- idle is combinational from the counters and the tag valids.
- route_err clears only on reset.
- Pipelining: back-to-back grants every cycle on every kernel must be sustained.

Decomposition:
- Shared package (plm_sched_pkg):
  - NKERNELS and CID_W derivations.
  - Tag struct {valid, consumer, wr}.
  - REQ_WIDTH / PLM_INPUT_WIDTH / PLM_OUTPUT_WIDTH formulas, shared with the scheduling kernel.
- Sub-module plm_tag_delay: one per kernel, a parameterised shift register of tag structs with async active-low clear.
- The top level holds the per-consumer priority mux, the counters and the error logic.

Test Plan:
- L=1, NCONSUMERS=2, NKERNELS=2: kernel 0 grants consumer 1 read at cycle 3, plm_outputs[0]=8'hA5 at cycle 4 -> resp_valid[1]=1, resp_data[1]=8'hA5 in cycle 5 only; outstanding[1] reads 1 in cycle 4 and 0 in cycle 5.
- Write grant, kernel 1 to consumer 0 at cycle 2 -> resp_wr_ack[0]=1 in cycle 4; resp_data[0] unchanged; resp_valid[0]=0.
- L=3, both kernels grant consumer 0 read in the same cycle, data 8'h11 on kernel 0 and 8'h22 on kernel 1 -> resp_data[0]=8'h11 4 cycles later; route_err=1; outstanding[0] returns to 0.
- Continuous grants every cycle for 20 cycles, alternating consumers -> 20 responses, in order, none lost; idle=1 exactly L+1 cycles after the last grant.
- reset_n pulled low while 2 tags are in flight -> no response pulses after release; all outputs 0; idle=1; route_err=0.
- grant_consumer=3 with NCONSUMERS=3 -> no response; route_err=1; all outstanding counters unchanged.
